// File: rtl/aurora_rtds_pkg.sv
// Shared definitions for the Aurora TX arbiter: FSM state encoding and default widths.
package aurora_rtds_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        S_ARB_IDLE   = 3'd0,
        S_ARB_GRANT0 = 3'd1,
        S_ARB_GRANT1 = 3'd2,
        S_ARB_DROP0  = 3'd3,
        S_ARB_DROP1  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/aurora_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing the Aurora TX AXI-Stream port between two sources.
// Frames longer than MAX_WORDS are cut with a forced tlast and the remainder is swallowed.
module aurora_tx_arbiter
    import aurora_rtds_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned MAX_WORDS  = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  user_clk,
    input  logic                  sys_reset_n,
    input  logic                  channel_up,
    input  logic                  s0_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic                  s1_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  frame_cnt0,
    output logic [CNT_WIDTH-1:0]  frame_cnt1,
    output logic                  err_len
);

    localparam int unsigned WC_WIDTH = $clog2(MAX_WORDS) + 1;
    localparam logic [WC_WIDTH-1:0] WC_LAST = WC_WIDTH'(MAX_WORDS - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic                 r_last_grant;
    logic [WC_WIDTH-1:0]  r_word_cnt;
    logic [CNT_WIDTH-1:0] r_frame_cnt0;
    logic [CNT_WIDTH-1:0] r_frame_cnt1;
    logic                 r_err_len;

    logic w_sel1;
    logic w_granted;
    logic w_dropping;
    logic w_src_tvalid;
    logic w_src_tlast;
    logic w_at_limit;
    logic w_beat;
    logic w_drop_beat;
    logic w_frame_end;
    logic w_trunc;

    // Per-cycle view of the currently owned source and the events it produces.
    always_comb begin
        w_sel1       = (r_state == S_ARB_GRANT1) || (r_state == S_ARB_DROP1);
        w_granted    = (r_state == S_ARB_GRANT0) || (r_state == S_ARB_GRANT1);
        w_dropping   = (r_state == S_ARB_DROP0) || (r_state == S_ARB_DROP1);
        w_src_tvalid = w_sel1 ? s1_axis_tvalid : s0_axis_tvalid;
        w_src_tlast  = w_sel1 ? s1_axis_tlast : s0_axis_tlast;
        w_at_limit   = (r_word_cnt == WC_LAST);
        w_beat       = w_granted && w_src_tvalid && m_axis_tready;
        // Drop states hold tready high, so every valid input beat is consumed.
        w_drop_beat  = w_dropping && w_src_tvalid;
        w_frame_end  = w_beat && (w_src_tlast || w_at_limit);
        w_trunc      = w_beat && w_at_limit && !w_src_tlast;
    end

    // State register.
    always_ff @(posedge user_clk) begin
        if (!sys_reset_n) begin
            r_state <= S_ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: round-robin pick in IDLE, frame end / truncation while granted.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_ARB_IDLE: begin
                if (channel_up && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    // last_grant==1 means source 0 is next in line on contention.
                    if (s0_axis_tvalid && (!s1_axis_tvalid || r_last_grant)) begin
                        w_state_next = S_ARB_GRANT0;
                    end else begin
                        w_state_next = S_ARB_GRANT1;
                    end
                end
            end
            S_ARB_GRANT0: begin
                if (w_beat) begin
                    if (s0_axis_tlast) begin
                        w_state_next = S_ARB_IDLE;
                    end else if (w_at_limit) begin
                        w_state_next = S_ARB_DROP0;
                    end
                end
            end
            S_ARB_GRANT1: begin
                if (w_beat) begin
                    if (s1_axis_tlast) begin
                        w_state_next = S_ARB_IDLE;
                    end else if (w_at_limit) begin
                        w_state_next = S_ARB_DROP1;
                    end
                end
            end
            S_ARB_DROP0: begin
                if (w_drop_beat && s0_axis_tlast) begin
                    w_state_next = S_ARB_IDLE;
                end
            end
            S_ARB_DROP1: begin
                if (w_drop_beat && s1_axis_tlast) begin
                    w_state_next = S_ARB_IDLE;
                end
            end
            default: w_state_next = S_ARB_IDLE;
        endcase
    end

    // Outputs: combinational passthrough of the granted source, sink-only while dropping.
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tlast   = 1'b0;
        unique case (r_state)
            S_ARB_GRANT0: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tlast   = s0_axis_tlast || w_at_limit;
                s0_axis_tready = m_axis_tready;
            end
            S_ARB_GRANT1: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tlast   = s1_axis_tlast || w_at_limit;
                s1_axis_tready = m_axis_tready;
            end
            S_ARB_DROP0: s0_axis_tready = 1'b1;
            S_ARB_DROP1: s1_axis_tready = 1'b1;
            default: ;
        endcase
    end

    // Word counter, per-source frame counters, sticky length error and round-robin pointer.
    always_ff @(posedge user_clk) begin
        if (!sys_reset_n) begin
            r_last_grant <= 1'b1;
            r_word_cnt   <= '0;
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
            r_err_len    <= 1'b0;
        end else begin
            if (w_beat) begin
                r_word_cnt <= w_frame_end ? '0 : r_word_cnt + WC_WIDTH'(1);
            end
            // A truncated frame counts as completed when its forced tlast goes out.
            if (w_frame_end) begin
                if (w_sel1) begin
                    r_frame_cnt1 <= r_frame_cnt1 + CNT_WIDTH'(1);
                end else begin
                    r_frame_cnt0 <= r_frame_cnt0 + CNT_WIDTH'(1);
                end
            end
            if (w_trunc) begin
                r_err_len <= 1'b1;
            end
            // Ownership passes only once the source's real tlast has been consumed.
            if ((w_beat || w_drop_beat) && w_src_tlast) begin
                r_last_grant <= w_sel1;
            end
        end
    end

    assign frame_cnt0 = r_frame_cnt0;
    assign frame_cnt1 = r_frame_cnt1;
    assign err_len    = r_err_len;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Self-checking bench for aurora_tx_arbiter: queue-fed source models, output monitor, scoreboard.
module tb_aurora_tx_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = 16;

    logic          user_clk = 1'b0;
    logic          sys_reset_n = 1'b0;
    logic          channel_up = 1'b1;
    logic          s0_axis_tvalid = 1'b0;
    logic [DW-1:0] s0_axis_tdata = '0;
    logic          s0_axis_tlast = 1'b0;
    logic          s0_axis_tready;
    logic          s1_axis_tvalid = 1'b0;
    logic [DW-1:0] s1_axis_tdata = '0;
    logic          s1_axis_tlast = 1'b0;
    logic          s1_axis_tready;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [CW-1:0] frame_cnt0;
    logic [CW-1:0] frame_cnt1;
    logic          err_len;

    aurora_tx_arbiter #(
        .DATA_WIDTH (DW),
        .MAX_WORDS  (MW),
        .CNT_WIDTH  (CW)
    ) dut (
        .user_clk       (user_clk),
        .sys_reset_n    (sys_reset_n),
        .channel_up     (channel_up),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .frame_cnt0     (frame_cnt0),
        .frame_cnt1     (frame_cnt1),
        .err_len        (err_len)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } obs_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];
    obs_t  obs_q[$];
    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;
    logic  hs0, hs1;

    always @(posedge user_clk) cyc <= cyc + 1;

    // Monitor: record every output beat with the cycle it occurred in.
    always @(negedge user_clk) begin
        if (sys_reset_n && m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back('{data: m_axis_tdata, last: m_axis_tlast, cyc: cyc});
        end
    end

    // Source models: present the head of each queue, pop it after a handshake.
    always begin
        @(negedge user_clk);
        hs0 = s0_axis_tvalid & s0_axis_tready;
        hs1 = s1_axis_tvalid & s1_axis_tready;
        @(posedge user_clk);
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            s0_axis_tvalid = 1'b1;
            s0_axis_tdata  = q0[0].data;
            s0_axis_tlast  = q0[0].last;
        end else begin
            s0_axis_tvalid = 1'b0;
            s0_axis_tlast  = 1'b0;
        end
        if (q1.size() > 0) begin
            s1_axis_tvalid = 1'b1;
            s1_axis_tdata  = q1[0].data;
            s1_axis_tlast  = q1[0].last;
        end else begin
            s1_axis_tvalid = 1'b0;
            s1_axis_tlast  = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(negedge user_clk);
        #1;
    endtask

    task automatic send(input int src, input logic [DW-1:0] d, input logic last);
        if (src == 0) q0.push_back('{data: d, last: last});
        else          q1.push_back('{data: d, last: last});
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic last);
        exp_q.push_back('{data: d, last: last});
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) break;
            sync();
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic apply_reset();
        sync();
        sys_reset_n   = 1'b0;
        m_axis_tready = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        obs_q.delete();
        repeat (2) sync();
        sys_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        sync();
        n_total++;
        if ({s0_axis_tready, s1_axis_tready, m_axis_tvalid, err_len} !== 4'b0000) begin
            $display("FAIL reset_outputs: got %b expected 0000",
                     {s0_axis_tready, s1_axis_tready, m_axis_tvalid, err_len});
        end else n_pass++;
        n_total++;
        if (frame_cnt0 !== '0) $display("FAIL reset_cnt0: got %0d expected 0", frame_cnt0);
        else n_pass++;
        n_total++;
        if (frame_cnt1 !== '0) $display("FAIL reset_cnt1: got %0d expected 0", frame_cnt1);
        else n_pass++;
    endtask

    task automatic test_single();
        int    t_push;
        bit    ok;
        beat_t e;
        obs_t  o;
        apply_reset();
        sync();
        t_push = cyc;
        send(0, 32'h5, 1'b0);
        send(0, 32'h3, 1'b1);
        push_exp(32'h5, 1'b0);
        push_exp(32'h3, 1'b1);
        wait_obs(2, 20, ok);
        n_total++;
        if (!ok) $display("FAIL single_timeout: got %0d beats expected 2", obs_q.size());
        else n_pass++;
        if (obs_q.size() >= 2) begin
            n_total++;
            if (obs_q[0].cyc != t_push + 2 || obs_q[1].cyc != t_push + 3) begin
                $display("FAIL single_latency: got cycles %0d,%0d expected %0d,%0d",
                         obs_q[0].cyc, obs_q[1].cyc, t_push + 2, t_push + 3);
            end else n_pass++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== e.data || o.last !== e.last) begin
                $display("FAIL single_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
            end else n_pass++;
        end
        repeat (2) sync();
        n_total++;
        if (frame_cnt0 !== CW'(1) || err_len !== 1'b0) begin
            $display("FAIL single_cnt: got cnt0=%0d err=%b expected cnt0=1 err=0", frame_cnt0, err_len);
        end else n_pass++;
    endtask

    task automatic test_contention();
        bit    ok;
        bit    gap_ok;
        beat_t e;
        obs_t  o;
        apply_reset();
        sync();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                send(0, DW'(32'hA0 + f * 16 + i), i == 2);
                send(1, DW'(32'hB0 + f * 16 + i), i == 2);
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) push_exp(DW'(32'hA0 + f * 16 + i), i == 2);
            for (int i = 0; i < 3; i++) push_exp(DW'(32'hB0 + f * 16 + i), i == 2);
        end
        wait_obs(12, 80, ok);
        n_total++;
        if (!ok) $display("FAIL contention_timeout: got %0d beats expected 12", obs_q.size());
        else n_pass++;
        // Beats within a frame are back to back; one dead cycle between frames.
        gap_ok = 1'b1;
        for (int k = 1; k < obs_q.size(); k++) begin
            if (obs_q[k].cyc - obs_q[k-1].cyc != ((k % 3 == 0) ? 2 : 1)) gap_ok = 1'b0;
        end
        n_total++;
        if (!gap_ok) $display("FAIL contention_gaps: got irregular spacing expected 1 idle per frame");
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== e.data || o.last !== e.last) begin
                $display("FAIL contention_beat: got %h/%b expected %h/%b",
                         o.data, o.last, e.data, e.last);
            end else n_pass++;
        end
        repeat (2) sync();
        n_total++;
        if (frame_cnt0 !== CW'(2) || frame_cnt1 !== CW'(2)) begin
            $display("FAIL contention_cnt: got %0d/%0d expected 2/2", frame_cnt0, frame_cnt1);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        int    bad0;
        int    bad1;
        beat_t e;
        obs_t  o;
        apply_reset();
        sync();
        for (int i = 0; i < 4; i++) begin
            send(1, DW'(32'hC1 + i), i == 3);
            push_exp(DW'(32'hC1 + i), i == 3);
        end
        bad0 = 0;
        bad1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (obs_q.size() >= 4) break;
            @(posedge user_clk);
            #2;
            m_axis_tready = ~m_axis_tready;
            sync();
            if (s0_axis_tready !== 1'b0) bad0++;
            if (m_axis_tvalid && s1_axis_tready !== m_axis_tready) bad1++;
        end
        m_axis_tready = 1'b1;
        n_total++;
        if (obs_q.size() != 4) $display("FAIL bp_count: got %0d beats expected 4", obs_q.size());
        else n_pass++;
        n_total++;
        if (bad0 != 0) $display("FAIL bp_s0_ready: got %0d high cycles expected 0", bad0);
        else n_pass++;
        n_total++;
        if (bad1 != 0) $display("FAIL bp_s1_mirror: got %0d mismatching cycles expected 0", bad1);
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== e.data || o.last !== e.last) begin
                $display("FAIL bp_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
            end else n_pass++;
        end
        repeat (2) sync();
        n_total++;
        if (frame_cnt1 !== CW'(1) || err_len !== 1'b0) begin
            $display("FAIL bp_cnt: got cnt1=%0d err=%b expected cnt1=1 err=0", frame_cnt1, err_len);
        end else n_pass++;
    endtask

    task automatic test_overlength();
        bit    ok;
        beat_t e;
        obs_t  o;
        apply_reset();
        sync();
        for (int i = 1; i <= 6; i++) send(0, DW'(i), i == 6);
        for (int i = 1; i <= 4; i++) push_exp(DW'(i), i == 4);
        wait_obs(4, 30, ok);
        for (int i = 0; i < 20; i++) begin
            if (q0.size() == 0) break;
            sync();
        end
        repeat (3) sync();
        n_total++;
        if (q0.size() != 0) $display("FAIL ovl_drain: got %0d beats left expected 0", q0.size());
        else n_pass++;
        n_total++;
        if (obs_q.size() != 4) $display("FAIL ovl_count: got %0d beats expected 4", obs_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== e.data || o.last !== e.last) begin
                $display("FAIL ovl_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
            end else n_pass++;
        end
        n_total++;
        if (err_len !== 1'b1 || frame_cnt0 !== CW'(1)) begin
            $display("FAIL ovl_status: got err=%b cnt0=%0d expected err=1 cnt0=1", err_len, frame_cnt0);
        end else n_pass++;
        obs_q.delete();
        send(0, 32'h7, 1'b1);
        push_exp(32'h7, 1'b1);
        wait_obs(1, 20, ok);
        repeat (2) sync();
        n_total++;
        if (!ok || obs_q.size() != 1 || obs_q[0].data !== 32'h7 || obs_q[0].last !== 1'b1) begin
            $display("FAIL ovl_next_frame: got %0d beats expected one beat 7 with tlast", obs_q.size());
        end else n_pass++;
        void'(exp_q.pop_front());
        n_total++;
        if (err_len !== 1'b1 || frame_cnt0 !== CW'(2)) begin
            $display("FAIL ovl_sticky: got err=%b cnt0=%0d expected err=1 cnt0=2", err_len, frame_cnt0);
        end else n_pass++;
    endtask

    task automatic test_channel_up();
        int    bad;
        bit    ok;
        beat_t e;
        obs_t  o;
        channel_up = 1'b0;
        apply_reset();
        sync();
        send(0, 32'hD1, 1'b1);
        send(1, 32'hE1, 1'b1);
        push_exp(32'hD1, 1'b1);
        push_exp(32'hE1, 1'b1);
        bad = 0;
        repeat (6) begin
            sync();
            if (m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0 || obs_q.size() != 0) begin
            $display("FAIL chan_down_grant: got %0d active cycles expected 0", bad);
        end else n_pass++;
        @(posedge user_clk);
        #2;
        channel_up = 1'b1;
        wait_obs(2, 20, ok);
        n_total++;
        if (!ok) $display("FAIL chan_up_timeout: got %0d beats expected 2", obs_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== e.data || o.last !== e.last) begin
                $display("FAIL chan_up_order: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit    ok;
        beat_t e;
        obs_t  o;
        apply_reset();
        sync();
        for (int i = 0; i < 3; i++) send(0, DW'(32'h11 + i), i == 2);
        wait_obs(1, 20, ok);
        sys_reset_n = 1'b0;
        q0.delete();
        q1.delete();
        n_total++;
        if (!ok || obs_q[0].data !== 32'h11 || obs_q[0].last !== 1'b0) begin
            $display("FAIL midrst_first: got %0d beats expected beat 11 without tlast", obs_q.size());
        end else n_pass++;
        obs_q.delete();
        exp_q.delete();
        sync();
        n_total++;
        if ({m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, err_len} !== 5'b0
            || frame_cnt0 !== '0 || frame_cnt1 !== '0) begin
            $display("FAIL midrst_state: got v=%b l=%b r0=%b r1=%b cnt0=%0d expected all 0",
                     m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, frame_cnt0);
        end else n_pass++;
        sys_reset_n = 1'b1;
        sync();
        // Full-length frame: a stale word count would force an early tlast.
        for (int i = 0; i < 4; i++) begin
            send(0, DW'(32'h21 + i), i == 3);
            push_exp(DW'(32'h21 + i), i == 3);
        end
        wait_obs(4, 20, ok);
        n_total++;
        if (!ok) $display("FAIL midrst_timeout: got %0d beats expected 4", obs_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== e.data || o.last !== e.last) begin
                $display("FAIL midrst_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
            end else n_pass++;
        end
        repeat (2) sync();
        n_total++;
        if (frame_cnt0 !== CW'(1) || err_len !== 1'b0) begin
            $display("FAIL midrst_cnt: got cnt0=%0d err=%b expected cnt0=1 err=0", frame_cnt0, err_len);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overlength();
        test_channel_up();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
Frame-atomic round-robin arbiter that shares the single Aurora TX AXI-Stream slave interface between two AXI-Stream requesters, for example a periodic stimulus generator and a host/DMA path.
- Sits between the requesters and the augmented-Aurora slave port.
- Runs entirely in the Aurora user clock domain.
- Enforces a per-frame word limit and keeps per-source frame counters for debug.

Parameters:
DATA_WIDTH, 32, width of tdata on all stream ports
MAX_WORDS, 64, maximum beats per frame; longer frames are truncated
CNT_WIDTH, 16, width of per-source frame counters

Ports:
user_clk  in  1  Aurora user clock; the only clock
sys_reset_n  in  1  synchronous, active-low reset
channel_up  in  1  Aurora channel ready; no new grant while low
s0_axis_tvalid  in  1  source 0 valid
s0_axis_tdata  in  DATA_WIDTH  source 0 data
s0_axis_tlast  in  1  source 0 end of frame
s0_axis_tready  out  1  source 0 ready
s1_axis_tvalid  in  1  source 1 valid
s1_axis_tdata  in  DATA_WIDTH  source 1 data
s1_axis_tlast  in  1  source 1 end of frame
s1_axis_tready  out  1  source 1 ready
m_axis_tvalid  out  1  to Aurora slave valid
m_axis_tdata  out  DATA_WIDTH  to Aurora slave data
m_axis_tlast  out  1  to Aurora slave last
m_axis_tready  in  1  from Aurora slave ready
frame_cnt0  out  CNT_WIDTH  frames completed from source 0 (wraps)
frame_cnt1  out  CNT_WIDTH  frames completed from source 1 (wraps)
err_len  out  1  sticky: a frame exceeded MAX_WORDS

Behaviour:
- Reset (sys_reset_n=0 at a user_clk edge) puts the block in this state:
  - state=IDLE, last_grant=1, so source 0 has first priority.
  - word_cnt=0, frame_cnt0/1=0, err_len=0.
  - All tready=0, m_axis_tvalid=0.
- Reset mid-frame abandons the frame immediately; no tlast is emitted.
- States: IDLE, GRANT0, GRANT1, DROP0, DROP1.
- IDLE:
  - All tready=0, m_axis_tvalid=0.
  - When channel_up=1 and any s*_tvalid=1, go to GRANTn on the next edge.
  - Selection is round-robin: prefer the source that is not last_grant. If only one source is valid, take it.
  - This gives one dead cycle between frames; first-beat latency is 1 cycle from tvalid.
- GRANTn, combinational passthrough:
  - m_axis_tvalid=sn_tvalid, m_axis_tdata=sn_tdata, sn_tready=m_axis_tready.
  - The other source's tready=0.
  - m_axis_tlast=sn_tlast OR (word_cnt==MAX_WORDS-1).
  - On each beat (m_axis_tvalid & m_axis_tready), word_cnt increments.
- Frame end in GRANTn, on a beat with sn_tlast=1:
  - frame_cntn+1, with wrap-around at 2^CNT_WIDTH.
  - last_grant<=n, word_cnt<=0, go to IDLE.
- Truncation in GRANTn, on a beat with word_cnt==MAX_WORDS-1 and sn_tlast=0:
  - The forced tlast goes out.
  - err_len<=1 (sticky until reset); frame_cntn+1; word_cnt<=0; go to DROPn.
  - If sn_tlast=1 on that same beat, the frame is normal: no error, go to IDLE.
- DROPn:
  - sn_tready=1, m_axis_tvalid=0, other source tready=0.
  - Input beats are discarded.
  - On a discarded beat with sn_tlast=1: last_grant<=n, go to IDLE.
- channel_up is sampled only in IDLE. A drop mid-frame does not abort the grant; Aurora backpressure governs.
- Each frame counter increments at most once per cycle; only one source can complete per cycle.
- word_cnt width is clog2(MAX_WORDS)+1. MAX_WORDS=1 means every beat carries a forced tlast.

Decomposition:
- Shared package aurora_rtds_pkg holds:
  - state encoding constants (S_ARB_IDLE, S_ARB_GRANT0, S_ARB_GRANT1, S_ARB_DROP0, S_ARB_DROP1);
  - the default DATA_WIDTH.
- No sub-module needed. An optional aurora_tx_mux (pure 2:1 stream mux driven by select) may be factored out, but the FSM and counters stay in this block.

Test Plan:
1. Single source: s0 sends 2-beat frame {0x5, 0x3, tlast on 0x3}, m_axis_tready=1.
   -> m sees 0x5 then 0x3 with tlast, starting 1 cycle after tvalid; frame_cnt0=1, err_len=0.
2. Contention: s0 and s1 both hold 3-beat frames continuously.
   -> Grants alternate s0, s1, s0, s1 with one idle cycle between frames; no beat interleaving; counters equal after 4 frames.
3. Backpressure: m_axis_tready toggles 1,0,1,0 during an s1 4-beat frame.
   -> Data order is preserved, s1_axis_tready mirrors m_axis_tready, s0_axis_tready=0 throughout.
4. Overlength: MAX_WORDS=4, s0 sends 6 beats 0x1..0x6 with tlast on 0x6.
   -> m outputs 0x1..0x4 with tlast on 0x4; 0x5 and 0x6 are accepted but not forwarded; err_len=1; frame_cnt0=1.
5. channel_up=0 while s0 and s1 are valid.
   -> No grant and m_axis_tvalid=0. Raise channel_up -> s0 is granted first after reset.
6. Reset mid-frame: assert sys_reset_n=0 after 1 of 3 beats.
   -> The next cycle shows all outputs at reset values; counters=0; the next frame is granted normally.
